cordic_sin_cos_dac_gen: RTL and testbench

Parametrised successor to the fixed-angle CORDIC sin/cos DAC top. It computes sin and cos of a phase with an iterative CORDIC core. It streams both results as offset-binary codes to a dual serial DAC: SDATA1 carries cos and SDATA2 carries sin, framed by NSYNC/SCLK. It adds a sweep mode in which a phase accumulator advances by `angle_in` every frame, producing a continuous quadrature sine generator.

---
 rtl/cordic_sin_cos_dac_gen_if.sv | 23 ++
 rtl/cordic_sin_cos_dac_gen.sv | 185 ++++++++++++++++++
 tb/tb_cordic_sin_cos_dac_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sin_cos_dac_gen_if.sv
// Phase/mode inputs and dual serial DAC outputs of the CORDIC sine generator.
// The master side drives the phase; the slave side is the generator itself.
interface cordic_sin_cos_dac_gen_if #(
    parameter int PHASE_W = 16
);
    logic [PHASE_W-1:0] angle_in;
    logic               mode;
    logic               SCLK;
    logic               SDATA1;
    logic               SDATA2;
    logic               NSYNC;
    logic               frame_done;

    modport master (
        output angle_in, mode,
        input  SCLK, SDATA1, SDATA2, NSYNC, frame_done
    );

    modport slave (
        input  angle_in, mode,
        output SCLK, SDATA1, SDATA2, NSYNC, frame_done
    );
endinterface

// File: rtl/cordic_sin_cos_dac_gen.sv
// Free-running iterative CORDIC sin/cos generator streaming offset-binary codes to a dual
// serial DAC (SDATA1 = cos, SDATA2 = sin), with a static-angle mode and a phase-sweep mode.
module cordic_sin_cos_dac_gen #(
    parameter int PHASE_W = 16,
    parameter int DAC_W   = 12,
    parameter int ITER    = 14,
    parameter int CLK_DIV = 2
) (
    input logic                     clk,
    input logic                     rst,
    cordic_sin_cos_dac_gen_if.slave bus
);
    // x/y carry GRD guard bits below the DAC LSB so shift truncation stays sub-LSB.
    localparam int GRD   = 2;
    localparam int XY_W  = DAC_W + 3;
    localparam int IT_W  = $clog2(ITER) + 1;
    localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;
    localparam int ASH   = 32 - PHASE_W;

    localparam longint X0_L = (longint'(2 ** (DAC_W - 1) - 1) * 607253 + 500000) / 1000000;
    localparam logic signed [XY_W-1:0] X0  = XY_W'(X0_L <<< GRD);
    localparam logic signed [XY_W-1:0] RND = XY_W'(2 ** (GRD - 1));

    typedef enum logic [2:0] {LOAD, CALC, CONV, SHIFT, QUIET} state_t;

    // atan(2^-i) in units of 2^-32 turn, rescaled and rounded to PHASE_W LSBs.
    function automatic logic signed [PHASE_W-1:0] atan_lsb(input logic [IT_W-1:0] i);
        longint t;
        case (int'(i))
            0:       t = 64'd536870912;
            1:       t = 64'd316933406;
            2:       t = 64'd167458907;
            3:       t = 64'd85004756;
            4:       t = 64'd42667331;
            5:       t = 64'd21354465;
            6:       t = 64'd10680862;
            7:       t = 64'd5340245;
            8:       t = 64'd2670163;
            9:       t = 64'd1335087;
            10:      t = 64'd667544;
            11:      t = 64'd333772;
            12:      t = 64'd166886;
            13:      t = 64'd83443;
            14:      t = 64'd41722;
            15:      t = 64'd20861;
            default: t = 64'd683565276 >> i;
        endcase
        t = (t + ((longint'(1) <<< ASH) >>> 1)) >>> ASH;
        return PHASE_W'(t);
    endfunction

    function automatic logic [15:0] to_frame(input logic signed [XY_W-1:0] v);
        logic signed [XY_W:0] c;
        c = {v[XY_W-1], v} + (XY_W + 1)'(2 ** (DAC_W - 1));
        if (c < 0) return 16'd0;
        if (c > (XY_W + 1)'(2 ** DAC_W - 1)) return 16'(2 ** DAC_W - 1);
        return 16'(c);
    endfunction

    state_t                    state_q;
    logic [PHASE_W-1:0]        acc_q;
    logic [1:0]                quad_q;
    logic signed [XY_W-1:0]    x_q, y_q;
    logic signed [PHASE_W-1:0] z_q;
    logic [IT_W-1:0]           iter_q;
    logic [DIV_W-1:0]          div_q;
    logic [3:0]                bit_q;
    logic [14:0]               sr1_q, sr2_q;
    logic                      sclk_q, sd1_q, sd2_q, nsync_q, done_q;

    logic [PHASE_W-1:0]        phase_d;
    logic signed [XY_W-1:0]    xr_d, yr_d, cos_d, sin_d;
    logic [15:0]               frame1_d, frame2_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        phase_d = bus.mode ? acc_q : bus.angle_in;
        xr_d    = (x_q + RND) >>> GRD;
        yr_d    = (y_q + RND) >>> GRD;
        cos_d   = xr_d;
        sin_d   = yr_d;
        case (quad_q)
            2'd1:    begin cos_d = -yr_d; sin_d = xr_d;  end
            2'd2:    begin cos_d = -xr_d; sin_d = -yr_d; end
            2'd3:    begin cos_d = yr_d;  sin_d = -xr_d; end
            default: begin cos_d = xr_d;  sin_d = yr_d;  end
        endcase
        frame1_d = to_frame(cos_d);
        frame2_d = to_frame(sin_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            acc_q   <= '0;
            quad_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sr1_q   <= '0;
            sr2_q   <= '0;
            sclk_q  <= 1'b1;
            sd1_q   <= 1'b0;
            sd2_q   <= 1'b0;
            nsync_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    acc_q   <= bus.mode ? acc_q + bus.angle_in : bus.angle_in;
                    quad_q  <= phase_d[PHASE_W-1 -: 2];
                    z_q     <= {2'b00, phase_d[PHASE_W-3:0]};
                    x_q     <= X0;
                    y_q     <= '0;
                    iter_q  <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    if (!z_q[PHASE_W-1]) begin
                        x_q <= x_q - (y_q >>> iter_q);
                        y_q <= y_q + (x_q >>> iter_q);
                        z_q <= z_q - atan_lsb(iter_q);
                    end else begin
                        x_q <= x_q + (y_q >>> iter_q);
                        y_q <= y_q - (x_q >>> iter_q);
                        z_q <= z_q + atan_lsb(iter_q);
                    end
                    iter_q <= iter_q + IT_W'(1);
                    if (iter_q == IT_W'(ITER - 1)) state_q <= CONV;
                end
                CONV: begin
                    sr1_q   <= frame1_d[14:0];
                    sr2_q   <= frame2_d[14:0];
                    sd1_q   <= frame1_d[15];
                    sd2_q   <= frame2_d[15];
                    nsync_q <= 1'b0;
                    sclk_q  <= 1'b1;
                    div_q   <= '0;
                    bit_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    div_q <= div_q + DIV_W'(1);
                    if (div_q == DIV_W'(CLK_DIV - 1)) sclk_q <= 1'b0;
                    if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
                        div_q  <= '0;
                        sclk_q <= 1'b1;
                        if (bit_q == 4'd15) begin
                            nsync_q <= 1'b1;
                            sd1_q   <= 1'b0;
                            sd2_q   <= 1'b0;
                            state_q <= QUIET;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            sd1_q <= sr1_q[14];
                            sd2_q <= sr2_q[14];
                            sr1_q <= {sr1_q[13:0], 1'b0};
                            sr2_q <= {sr2_q[13:0], 1'b0};
                        end
                    end
                end
                QUIET: begin
                    div_q <= div_q + DIV_W'(1);
                    if (div_q == DIV_W'(2 * CLK_DIV - 1)) begin
                        div_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.SCLK       = sclk_q;
    assign bus.SDATA1     = sd1_q;
    assign bus.SDATA2     = sd2_q;
    assign bus.NSYNC      = nsync_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_cordic_sin_cos_dac_gen.sv
// Directed bench for cordic_sin_cos_dac_gen: decodes each NSYNC-low window on SCLK falling
// edges and compares the cos/sin codes and frame timing against hand-computed values.
`timescale 1ns/1ps
module tb_cordic_sin_cos_dac_gen;
    localparam int PHASE_W   = 16;
    localparam int DAC_W     = 12;
    localparam int ITER      = 14;
    localparam int CLK_DIV   = 2;
    localparam int FRAME_CYC = 84;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cordic_sin_cos_dac_gen_if #(.PHASE_W(PHASE_W)) dut_if ();

    cordic_sin_cos_dac_gen #(
        .PHASE_W(PHASE_W),
        .DAC_W  (DAC_W),
        .ITER   (ITER),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dut_if)
    );

    always #5 clk = ~clk;

    // Serial receiver: a frame counts only if all 16 bits arrived outside reset.
    logic [15:0] rx1 = '0, rx2 = '0, f_cos = '0, f_sin = '0;
    int          rx_bits = 0;
    int          frames = 0;

    always @(negedge dut_if.SCLK) begin
        if (dut_if.NSYNC === 1'b0) begin
            rx1 = {rx1[14:0], dut_if.SDATA1};
            rx2 = {rx2[14:0], dut_if.SDATA2};
            rx_bits++;
        end
    end

    always @(posedge dut_if.NSYNC) begin
        if (rx_bits == 16 && rst === 1'b1) begin
            f_cos = rx1;
            f_sin = rx2;
            frames++;
        end
        rx_bits = 0;
    end

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic wait_frames(input int n, input string tag, output bit ok);
        int target;
        target = frames + n;
        ok = 1'b0;
        for (int c = 0; c < n * FRAME_CYC + 50; c++) begin
            @(posedge clk);
            if (frames >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout, got %0d frames want %0d", tag, frames, target);
        end
        #1;
    endtask

    task automatic wait_nsync_low(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2 * FRAME_CYC; c++) begin
            @(posedge clk);
            #1;
            if (dut_if.NSYNC === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL nsync_wait: NSYNC never fell, got %b want 0", dut_if.NSYNC);
        end
    endtask

    task automatic test_reset();
        int fall, rise, d1, d2;
        fall = -1; rise = -1; d1 = -1; d2 = -1;
        rst = 1'b0;
        dut_if.mode = 1'b0;
        dut_if.angle_in = 16'h0000;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (dut_if.NSYNC !== 1'b1) begin miscompares++; $display("FAIL rst_nsync: got %b want 1", dut_if.NSYNC); end
        if (dut_if.SCLK !== 1'b1) begin miscompares++; $display("FAIL rst_sclk: got %b want 1", dut_if.SCLK); end
        if (dut_if.SDATA1 !== 1'b0) begin miscompares++; $display("FAIL rst_sdata1: got %b want 0", dut_if.SDATA1); end
        if (dut_if.SDATA2 !== 1'b0) begin miscompares++; $display("FAIL rst_sdata2: got %b want 0", dut_if.SDATA2); end
        if (dut_if.frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", dut_if.frame_done); end
        rst = 1'b1;
        for (int c = 1; c <= 2 * FRAME_CYC + 2; c++) begin
            @(posedge clk);
            #1;
            if (fall < 0 && dut_if.NSYNC === 1'b0) fall = c;
            if (fall >= 0 && rise < 0 && dut_if.NSYNC === 1'b1) rise = c;
            if (dut_if.frame_done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        vectors += 6;
        if (fall !== 16) begin miscompares++; $display("FAIL nsync_fall: got cycle %0d want 16", fall); end
        if (rise !== 80) begin miscompares++; $display("FAIL nsync_rise: got cycle %0d want 80", rise); end
        if (d1 !== 84) begin miscompares++; $display("FAIL done_first: got cycle %0d want 84", d1); end
        if (d2 !== 168) begin miscompares++; $display("FAIL done_second: got cycle %0d want 168", d2); end
        if (absdiff(int'(f_cos), 4095) > 2) begin miscompares++; $display("FAIL first_cos: got %0d want 4095+-2", f_cos); end
        if (absdiff(int'(f_sin), 2048) > 2) begin miscompares++; $display("FAIL first_sin: got %0d want 2048+-2", f_sin); end
    endtask

    task automatic test_static();
        logic [15:0] ang [5] = '{16'h0000, 16'h4000, 16'h2000, 16'h8000, 16'hC000};
        int          ec  [5] = '{4095, 2048, 3495, 1, 2048};
        int          es  [5] = '{2048, 4095, 3495, 2048, 1};
        bit          ok;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dut_if.mode = 1'b0;
            dut_if.angle_in = ang[k];
            wait_frames(2, "static", ok);
            if (!ok) return;
            vectors += 3;
            if (absdiff(int'(f_cos), ec[k]) > 2) begin
                miscompares++; $display("FAIL static_cos[%h]: got %0d want %0d+-2", ang[k], f_cos, ec[k]);
            end
            if (absdiff(int'(f_sin), es[k]) > 2) begin
                miscompares++; $display("FAIL static_sin[%h]: got %0d want %0d+-2", ang[k], f_sin, es[k]);
            end
            if ({f_cos[15:12], f_sin[15:12]} !== 8'h00) begin
                miscompares++; $display("FAIL lead_zeros[%h]: got %h/%h want 0/0", ang[k], f_cos[15:12], f_sin[15:12]);
            end
        end
    endtask

    task automatic test_sweep();
        int sn [16] = '{2048, 2831, 3495, 3939, 4095, 3939, 3495, 2831,
                        2048, 1265, 601, 157, 1, 157, 601, 1265};
        bit ok;
        @(negedge clk);
        rst = 1'b0;
        dut_if.mode = 1'b1;
        dut_if.angle_in = 16'h1000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            wait_frames(1, "sweep", ok);
            if (!ok) return;
            vectors += 2;
            if (absdiff(int'(f_cos), sn[(k + 4) % 16]) > 2) begin
                miscompares++; $display("FAIL sweep_cos[%0d]: got %0d want %0d+-2", k, f_cos, sn[(k + 4) % 16]);
            end
            if (absdiff(int'(f_sin), sn[k % 16]) > 2) begin
                miscompares++; $display("FAIL sweep_sin[%0d]: got %0d want %0d+-2", k, f_sin, sn[k % 16]);
            end
        end
    endtask

    task automatic test_mid_frame_change();
        int ec [3] = '{2048, 2048, 1265};
        int es [3] = '{4095, 4095, 3939};
        bit ok;
        @(negedge clk);
        dut_if.mode = 1'b0;
        dut_if.angle_in = 16'h0000;
        wait_frames(2, "mid_setup", ok);
        if (!ok) return;
        wait_nsync_low(ok);
        if (!ok) return;
        repeat (20) @(negedge clk);
        dut_if.angle_in = 16'h4000;
        wait_frames(1, "mid_cur", ok);
        if (!ok) return;
        vectors += 2;
        if (absdiff(int'(f_cos), 4095) > 2) begin miscompares++; $display("FAIL mid_cur_cos: got %0d want 4095+-2", f_cos); end
        if (absdiff(int'(f_sin), 2048) > 2) begin miscompares++; $display("FAIL mid_cur_sin: got %0d want 2048+-2", f_sin); end
        wait_nsync_low(ok);
        if (!ok) return;
        repeat (20) @(negedge clk);
        dut_if.mode = 1'b1;
        dut_if.angle_in = 16'h1000;
        // Current frame, then the sweep starting at the last static angle, then one step on.
        for (int k = 0; k < 3; k++) begin
            wait_frames(1, "mode_switch", ok);
            if (!ok) return;
            vectors += 2;
            if (absdiff(int'(f_cos), ec[k]) > 2) begin
                miscompares++; $display("FAIL switch_cos[%0d]: got %0d want %0d+-2", k, f_cos, ec[k]);
            end
            if (absdiff(int'(f_sin), es[k]) > 2) begin
                miscompares++; $display("FAIL switch_sin[%0d]: got %0d want %0d+-2", k, f_sin, es[k]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int ec [2] = '{4095, 3939};
        int es [2] = '{2048, 2831};
        bit ok;
        @(negedge clk);
        dut_if.mode = 1'b1;
        dut_if.angle_in = 16'h1000;
        wait_nsync_low(ok);
        if (!ok) return;
        repeat (7 * 2 * CLK_DIV + 1) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        vectors += 4;
        if (dut_if.NSYNC !== 1'b1) begin miscompares++; $display("FAIL async_nsync: got %b want 1", dut_if.NSYNC); end
        if (dut_if.SCLK !== 1'b1) begin miscompares++; $display("FAIL async_sclk: got %b want 1", dut_if.SCLK); end
        if (dut_if.SDATA1 !== 1'b0) begin miscompares++; $display("FAIL async_sdata1: got %b want 0", dut_if.SDATA1); end
        if (dut_if.SDATA2 !== 1'b0) begin miscompares++; $display("FAIL async_sdata2: got %b want 0", dut_if.SDATA2); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_frames(1, "post_reset", ok);
            if (!ok) return;
            vectors += 2;
            if (absdiff(int'(f_cos), ec[k]) > 2) begin
                miscompares++; $display("FAIL post_rst_cos[%0d]: got %0d want %0d+-2", k, f_cos, ec[k]);
            end
            if (absdiff(int'(f_sin), es[k]) > 2) begin
                miscompares++; $display("FAIL post_rst_sin[%0d]: got %0d want %0d+-2", k, f_sin, es[k]);
            end
        end
    endtask

    initial begin
        dut_if.mode = 1'b0;
        dut_if.angle_in = '0;
        test_reset();
        test_static();
        test_sweep();
        test_mid_frame_change();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
